// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin arbiter and sequencer for one shared ALU.
// A granted request runs IDLE -> EXEC -> RESP. The ALU result is captured in EXEC
// and then held on the winner's response channel until that requester takes it.
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [CTRL_W-1:0] req1_ctrl,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic              rsp0_zero,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic              rsp1_zero,
  output logic [DATA_W-1:0] alu_operand_a,
  output logic [DATA_W-1:0] alu_operand_b,
  output logic [CTRL_W-1:0] alu_control,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state;
  logic              prio;
  logic              gnt;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] res_q;
  logic              zero_q;
  logic              rsp0_q;
  logic              rsp1_q;
  logic              busy_q;
  logic              grant0;
  logic              grant1;
  logic              rsp_take;

  // Pick the winner in IDLE. This path uses only the valids, the state and prio.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && (!req1_valid || !prio)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp_take   = gnt ? rsp1_ready : rsp0_ready;

  // Sequencer: latch the winning request, capture the ALU output, hold the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      prio   <= 1'b0;
      gnt    <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      ctrl_q <= '0;
      res_q  <= '0;
      zero_q <= 1'b0;
      rsp0_q <= 1'b0;
      rsp1_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            op_a   <= grant1 ? req1_a    : req0_a;
            op_b   <= grant1 ? req1_b    : req0_b;
            ctrl_q <= grant1 ? req1_ctrl : req0_ctrl;
            gnt    <= grant1;
            busy_q <= 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          res_q  <= alu_result;
          zero_q <= alu_zero;
          rsp0_q <= ~gnt;
          rsp1_q <= gnt;
          state  <= RESP;
        end
        RESP: begin
          if (rsp_take) begin
            rsp0_q <= 1'b0;
            rsp1_q <= 1'b0;
            prio   <= ~gnt;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign alu_operand_a = op_a;
  assign alu_operand_b = op_b;
  assign alu_control   = ctrl_q;
  assign rsp0_valid    = rsp0_q;
  assign rsp1_valid    = rsp1_q;
  assign rsp0_result   = res_q;
  assign rsp1_result   = res_q;
  assign rsp0_zero     = zero_q;
  assign rsp1_zero     = zero_q;
  assign busy          = busy_q;

endmodule
